// File: rtl/rr_merge2_if.sv
// Handshake bundle for the two-input round-robin merge: two producer
// channels in, one tagged output channel out.
interface rr_merge2_if #(
  parameter int WIDTH = 8
);
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req2_valid;
  logic             req2_ready;
  logic [WIDTH-1:0] req2_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;

  // Producer/consumer side: drives request channels and output ready.
  modport master (
    output req1_valid, req1_data, req2_valid, req2_data, out_ready,
    input  req1_ready, req2_ready, out_valid, out_data, out_sel
  );

  // Merge side: accepts request channels and drives the output channel.
  modport slave (
    input  req1_valid, req1_data, req2_valid, req2_data, out_ready,
    output req1_ready, req2_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_merge2.sv
// Two-input round-robin merge with an in-order output queue.
// Each queued word carries its source tag (0 = req1, 1 = req2).
// Per-input grant counters saturate at all-ones.
module rr_merge2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  rr_merge2_if.slave       bus,
  output logic [CNT_W-1:0] grant1_cnt,
  output logic [CNT_W-1:0] grant2_cnt
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_QW = $clog2(DEPTH + 1);
  localparam logic [CNT_QW-1:0] DEPTH_Q = CNT_QW'(DEPTH);

  logic [WIDTH-1:0]  mem_data [DEPTH];
  logic              mem_sel  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_QW-1:0] count;
  logic              last_win;

  logic grant_vld;
  logic grant_sel;
  logic space;
  logic push;
  logic pop;
  logic head_vld;

  // Round-robin grant: a tie goes to the input that did not win last.
  always_comb begin
    grant_vld = bus.req1_valid | bus.req2_valid;
    grant_sel = 1'b0;
    if (bus.req1_valid && bus.req2_valid) begin
      grant_sel = ~last_win;
    end else if (bus.req2_valid) begin
      grant_sel = 1'b1;
    end
  end

  // Handshake and output view; empty queue reads as zero, no bypass.
  always_comb begin
    head_vld       = (count != '0);
    pop            = head_vld & bus.out_ready;
    space          = (count < DEPTH_Q) | pop;
    push           = ~reset & space & grant_vld;
    bus.req1_ready = push & ~grant_sel;
    bus.req2_ready = push & grant_sel;
    bus.out_valid  = head_vld;
    bus.out_data   = head_vld ? mem_data[rd_ptr] : '0;
    bus.out_sel    = head_vld ? mem_sel[rd_ptr] : 1'b0;
  end

  // Queue storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= grant_sel ? bus.req2_data : bus.req1_data;
      mem_sel[wr_ptr]  <= grant_sel;
    end
  end

  // Queue pointers, occupancy and round-robin priority state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last_win <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        last_win <= grant_sel;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_QW'(1);
        2'b01:   count <= count - CNT_QW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating grant counters for fairness monitoring.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant1_cnt <= '0;
      grant2_cnt <= '0;
    end else if (push) begin
      if (!grant_sel && (grant1_cnt != '1)) begin
        grant1_cnt <= grant1_cnt + CNT_W'(1);
      end
      if (grant_sel && (grant2_cnt != '1)) begin
        grant2_cnt <= grant2_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_merge2.sv
// Bench for rr_merge2: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the merge.
module tb_rr_merge2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  logic [15:0] grant1_cnt, grant2_cnt;
  logic [3:0]  grant1_cnt_s, grant2_cnt_s;

  rr_merge2_if #(.WIDTH(WIDTH)) bus ();
  rr_merge2_if #(.WIDTH(WIDTH)) bus_s ();

  rr_merge2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .bus(bus),
    .grant1_cnt(grant1_cnt), .grant2_cnt(grant2_cnt)
  );

  rr_merge2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_s (
    .clk(clk), .reset(rst), .bus(bus_s),
    .grant1_cnt(grant1_cnt_s), .grant2_cnt(grant2_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH:0] mq[$];
  bit             m_last_win;
  int             m_cnt1, m_cnt2;
  bit             m_pop, m_g;
  bit             exp_r1, exp_r2, exp_ov, exp_os;
  logic [WIDTH-1:0] exp_od;

  task automatic model_eval();
    bit any, spc;
    exp_ov = (mq.size() != 0);
    exp_od = exp_ov ? mq[0][WIDTH-1:0] : '0;
    exp_os = exp_ov ? mq[0][WIDTH] : 1'b0;
    m_pop  = exp_ov && bus.out_ready;
    spc    = (mq.size() < DEPTH) || m_pop;
    any    = bus.req1_valid || bus.req2_valid;
    if (bus.req1_valid && bus.req2_valid) m_g = m_last_win ? 1'b0 : 1'b1;
    else m_g = bus.req2_valid;
    exp_r1 = !rst && spc && any && (m_g == 1'b0);
    exp_r2 = !rst && spc && any && (m_g == 1'b1);
  endtask

  task automatic model_commit();
    if (rst) begin
      mq.delete();
      m_last_win = 1'b1;
      m_cnt1 = 0;
      m_cnt2 = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (exp_r1 || exp_r2) begin
        mq.push_back({m_g, m_g ? bus.req2_data : bus.req1_data});
        m_last_win = m_g;
        if (m_g) m_cnt2 = (m_cnt2 < 65535) ? m_cnt2 + 1 : m_cnt2;
        else     m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v1, input logic [7:0] d1, input bit v2,
                       input logic [7:0] d2, input bit ordy);
    bus.req1_valid = v1; bus.req1_data = d1;
    bus.req2_valid = v2; bus.req2_data = d2;
    bus.out_ready  = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 1);
    @(posedge clk); #1;
    sample();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 8'hAA, 1, 8'h55, 0);
    @(posedge clk); #1;
    mq.delete(); m_last_win = 1'b1; m_cnt1 = 0; m_cnt2 = 0;
    sample();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00 || bus.out_sel !== 1'b0) begin n_fail++; $display("FAIL reset_out_data: got %h/%b expected 00/0", bus.out_data, bus.out_sel); end
    n_checks++; if (grant1_cnt !== 16'd0 || grant2_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", grant1_cnt, grant2_cnt); end
    n_checks++; if (bus.req1_ready !== 1'b0 || bus.req2_ready !== 1'b0) begin n_fail++; $display("FAIL reset_readies: got %b%b expected 00", bus.req1_ready, bus.req2_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_req1_only();
    do_reset();
    drive(1, 8'h01, 0, 8'h00, 1);
    sample();
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req1_ready !== exp_r1) begin n_fail++; $display("FAIL req1_only_ready: got %b expected 1", bus.req1_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL req1_only_no_bypass: got %b expected 0", bus.out_valid); end
    step();
    drive(0, 8'h00, 0, 8'h00, 1);
    sample();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01 || bus.out_sel !== 1'b0) begin n_fail++; $display("FAIL req1_only_out: got %b/%h/%b expected 1/01/0", bus.out_valid, bus.out_data, bus.out_sel); end
    n_checks++; if (grant1_cnt !== 16'd1) begin n_fail++; $display("FAIL req1_only_cnt: got %0d expected 1", grant1_cnt); end
    step();
  endtask

  task automatic test_req2_only();
    drive(0, 8'h00, 1, 8'h02, 1);
    sample();
    n_checks++; if (bus.req2_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL req2_only_ready: got %b%b expected 01", bus.req1_ready, bus.req2_ready); end
    step();
    drive(0, 8'h00, 0, 8'h00, 1);
    sample();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02 || bus.out_sel !== 1'b1) begin n_fail++; $display("FAIL req2_only_out: got %b/%h/%b expected 1/02/1", bus.out_valid, bus.out_data, bus.out_sel); end
    n_checks++; if (grant2_cnt !== 16'd1 || grant1_cnt !== 16'd1) begin n_fail++; $display("FAIL req2_only_cnt: got %0d/%0d expected 1/1", grant1_cnt, grant2_cnt); end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    drive(1, 8'h01, 1, 8'h02, 1);
    for (int i = 0; i < 16; i++) begin
      sample();
      n_checks++; if (bus.req1_ready !== (i % 2 == 0) || bus.req2_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b%b expected %b%b", i, bus.req1_ready, bus.req2_ready, (i % 2 == 0), (i % 2 == 1)); end
      if (i > 0) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== ((i - 1) % 2 == 1)) begin n_fail++; $display("FAIL contention_sel[%0d]: got %b expected %b", i, bus.out_sel, ((i - 1) % 2 == 1)); end
      end
      step();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    sample();
    n_checks++; if (grant1_cnt !== 16'd8 || grant2_cnt !== 16'd8) begin n_fail++; $display("FAIL contention_cnt: got %0d/%0d expected 8/8", grant1_cnt, grant2_cnt); end
    n_checks++; if (bus.out_sel !== 1'b1 || bus.out_data !== 8'h02) begin n_fail++; $display("FAIL contention_last: got %h/%b expected 02/1", bus.out_data, bus.out_sel); end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, 8'h01, 1, 8'h02, 0);
    for (int i = 0; i < 6; i++) begin
      sample();
      n_checks++; if (bus.req1_ready !== (i == 0) || bus.req2_ready !== (i == 1)) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b%b expected %b%b", i, bus.req1_ready, bus.req2_ready, (i == 0), (i == 1)); end
      if (i > 0) begin
        n_checks++; if (bus.out_data !== 8'h01 || bus.out_sel !== 1'b0) begin n_fail++; $display("FAIL bp_head[%0d]: got %h/%b expected 01/0", i, bus.out_data, bus.out_sel); end
      end
      step();
    end
    bus.out_ready = 1'b1;
    sample();
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req2_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b%b expected 10", bus.req1_ready, bus.req2_ready); end
    step();
    bus.out_ready = 1'b0;
    sample();
    n_checks++; if (bus.out_data !== 8'h02 || bus.out_sel !== 1'b1) begin n_fail++; $display("FAIL bp_next_head: got %h/%b expected 02/1", bus.out_data, bus.out_sel); end
    n_checks++; if (grant1_cnt !== 16'd2 || grant2_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d/%0d expected 2/1", grant1_cnt, grant2_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 8'h11, 1, 8'h22, 0);
    for (int i = 0; i < 3; i++) begin sample(); step(); end
    rst = 1'b1;
    sample();
    n_checks++; if (bus.req1_ready !== 1'b0 || bus.req2_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_readies: got %b%b expected 00", bus.req1_ready, bus.req2_ready); end
    step();
    rst = 1'b0;
    sample();
    n_checks++; if (bus.out_valid !== 1'b0 || grant1_cnt !== 16'd0 || grant2_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_state: got %b/%0d/%0d expected 0/0/0", bus.out_valid, grant1_cnt, grant2_cnt); end
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req2_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_tie: got %b%b expected 10", bus.req1_ready, bus.req2_ready); end
    step();
  endtask

  task automatic test_random();
    bit v1, v2;
    logic [7:0] d1, d2;
    v1 = 0; v2 = 0; d1 = 0; d2 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!(v1 && !exp_r1) || rst) begin v1 = ($urandom_range(0, 2) != 0); d1 = 8'($urandom); end
      if (!(v2 && !exp_r2) || rst) begin v2 = ($urandom_range(0, 2) != 0); d2 = 8'($urandom); end
      rst = ($urandom_range(0, 49) == 0);
      drive(v1, d1, v2, d2, ($urandom_range(0, 3) != 0));
      sample();
      n_checks++; if (bus.req1_ready !== exp_r1 || bus.req2_ready !== exp_r2) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", i, bus.req1_ready, bus.req2_ready, exp_r1, exp_r2); end
      n_checks++; if (bus.out_valid !== exp_ov || bus.out_data !== exp_od || bus.out_sel !== exp_os) begin n_fail++; $display("FAIL rand_out[%0d]: got %b/%h/%b expected %b/%h/%b", i, bus.out_valid, bus.out_data, bus.out_sel, exp_ov, exp_od, exp_os); end
      n_checks++; if (grant1_cnt !== 16'(m_cnt1) || grant2_cnt !== 16'(m_cnt2)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, grant1_cnt, grant2_cnt, m_cnt1, m_cnt2); end
      step();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    bus_s.req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_s.req1_data = 8'(i);
      sample();
      n_checks++; if (bus_s.req1_ready !== 1'b1 || grant1_cnt_s !== 4'((i < 15) ? i : 15)) begin n_fail++; $display("FAIL sat_step[%0d]: got %b/%0d expected 1/%0d", i, bus_s.req1_ready, grant1_cnt_s, (i < 15) ? i : 15); end
      step();
    end
    bus_s.req1_valid = 1'b0;
    sample();
    n_checks++; if (grant1_cnt_s !== 4'd15 || grant2_cnt_s !== 4'd0) begin n_fail++; $display("FAIL sat_final: got %0d/%0d expected 15/0", grant1_cnt_s, grant2_cnt_s); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    bus_s.req1_valid = 1'b0; bus_s.req1_data = 8'h00;
    bus_s.req2_valid = 1'b0; bus_s.req2_data = 8'h00;
    bus_s.out_ready  = 1'b1;
    test_reset();
    test_req1_only();
    test_req2_only();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
